// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu -- 8-bit, 16-function arithmetic/logic unit with a registered 13-bit
// result. Operands and function select are sampled on every rising clock edge,
// and the selected function's value appears on `result` one cycle later.
// A new operation is accepted every cycle. There is no handshake.
//
// Ports
//   clk     in   1   single clock, rising-edge active
//   rst_n   in   1   asynchronous active-low reset; clears result to zero
//   a       in   8   operand A, unsigned
//   b       in   8   operand B, unsigned
//   sel     in   4   function select (all 16 codes defined)
//   result  out  13  registered function output
// -----------------------------------------------------------------------------
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [3:0]  sel,
  output logic [12:0] result
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_DIV  = 4'h3,
    OP_MOD  = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_XOR  = 4'h7,
    OP_NAND = 4'h8,
    OP_NOR  = 4'h9,
    OP_XNOR = 4'hA,
    OP_NOT  = 4'hB,
    OP_SHL  = 4'hC,
    OP_SHR  = 4'hD,
    OP_ROL  = 4'hE,
    OP_CMP  = 4'hF
  } op_e;

  logic [15:0] w_prod;
  logic [12:0] w_next;
  logic [12:0] r_result;

  // Full 16-bit product. Only the low 13 bits are kept for MUL.
  assign w_prod = {8'b0, a} * {8'b0, b};

  always_comb begin
    // NOTE: default assignment first so every path drives w_next (no latch).
    w_next = '0;
    case (op_e'(sel))
      OP_ADD:  w_next = {4'b0, {1'b0, a} + {1'b0, b}};
      // Zero-extending to 13 bits before subtracting gives the two's-complement wrap.
      OP_SUB:  w_next = {5'b0, a} - {5'b0, b};
      OP_MUL:  w_next = w_prod[12:0];
      OP_DIV:  w_next = (b == 8'd0) ? 13'h1FFF : {5'b0, a / b};
      OP_MOD:  w_next = (b == 8'd0) ? {5'b0, a} : {5'b0, a % b};
      OP_AND:  w_next = {5'b0, a & b};
      OP_OR:   w_next = {5'b0, a | b};
      OP_XOR:  w_next = {5'b0, a ^ b};
      OP_NAND: w_next = {5'b0, ~(a & b)};
      OP_NOR:  w_next = {5'b0, ~(a | b)};
      OP_XNOR: w_next = {5'b0, ~(a ^ b)};
      OP_NOT:  w_next = {5'b0, ~a};
      OP_SHL:  w_next = {4'b0, a, 1'b0};
      OP_SHR:  w_next = {6'b0, a[7:1]};
      OP_ROL:  w_next = {5'b0, a[6:0], a[7]};
      // Exactly one of greater / equal / less is set.
      OP_CMP:  w_next = {10'b0, (a > b), (a == b), (a < b)};
      default: w_next = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
    end else begin
      r_result <= w_next;
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu. Directed steps cover reset, an opcode
// sweep, boundaries, divide-by-zero and compare. Random back-to-back traffic is
// then checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  a     = 8'd0;
  logic [7:0]  b     = 8'd0;
  logic [3:0]  sel   = 4'd0;
  logic [12:0] result;

  int checks   = 0;
  int failures = 0;

  alu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .sel    (sel),
    .result (result)
  );

  always #5 clk = ~clk;

  // Expected results for a=6, b=2 with sel = 0..15.
  localparam logic [12:0] SWEEP_EXP [16] = '{
    13'd8, 13'd4, 13'd12, 13'd3, 13'd0, 13'd2, 13'd6, 13'd4,
    13'h0FD, 13'h0F9, 13'h0FB, 13'h0F9, 13'd12, 13'd3, 13'd12, 13'h004
  };

  // Reference model: plain integer arithmetic on the function definitions.
  function automatic logic [12:0] ref_alu(input int x, input int y, input int op);
    int v;
    case (op)
      0:  v = x + y;
      1:  v = x - y;
      2:  v = x * y;
      3:  v = (y == 0) ? 8191 : x / y;
      4:  v = (y == 0) ? x : x % y;
      5:  v = x & y;
      6:  v = x | y;
      7:  v = x ^ y;
      8:  v = 255 - (x & y);
      9:  v = 255 - (x | y);
      10: v = 255 - (x ^ y);
      11: v = 255 - x;
      12: v = x * 2;
      13: v = x / 2;
      14: v = ((x * 2) % 256) + (x / 128);
      default: v = (x > y) ? 4 : ((x == y) ? 2 : 1);
    endcase
    return 13'(v & 8191);
  endfunction

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one operation at the falling edge, then sample just after the next rising edge.
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic [3:0] isel,
                        input logic [12:0] exp, input string tag);
    @(negedge clk);
    a = ia; b = ib; sel = isel;
    @(posedge clk);
    #1;
    check(tag, result, exp);
  endtask

  initial begin
    logic [7:0]  ra, rb;
    logic [3:0]  rs;
    logic [12:0] held;

    // Reset state, held through clock edges while low.
    #1;
    check("reset_initial", result, 13'h0);
    a = 8'hFF; b = 8'hFF; sel = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_held_edges", result, 13'h0);

    // Release with a live op: the first edge loads it.
    @(negedge clk);
    a = 8'd6; b = 8'd2; sel = 4'h0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_first_op", result, 13'd8);

    // Sweep all functions with a=6, b=2.
    for (int i = 0; i < 16; i++) begin
      run_op(8'd6, 8'd2, 4'(i), SWEEP_EXP[i], $sformatf("sweep_sel%0d", i));
    end

    // Boundaries.
    run_op(8'd255, 8'd255, 4'h0, 13'h1FE,  "add_255_255");
    run_op(8'd0,   8'd1,   4'h1, 13'h1FFF, "sub_0_1");
    run_op(8'd255, 8'd255, 4'h2, 13'h1E01, "mul_255_255");
    run_op(8'h80,  8'd0,   4'hC, 13'h100,  "shl_0x80");
    run_op(8'h81,  8'd0,   4'hE, 13'h003,  "rol_0x81");

    // Divide by zero and its non-zero counterpart.
    run_op(8'd9, 8'd0, 4'h3, 13'h1FFF, "div_by_zero");
    run_op(8'd9, 8'd0, 4'h4, 13'd9,    "mod_by_zero");
    run_op(8'd9, 8'd4, 4'h3, 13'd2,    "div_9_4");
    run_op(8'd9, 8'd4, 4'h4, 13'd1,    "mod_9_4");

    // Compare.
    run_op(8'd5, 8'd5, 4'hF, 13'h002, "cmp_eq");
    run_op(8'd3, 8'd7, 4'hF, 13'h001, "cmp_lt");
    run_op(8'd7, 8'd3, 4'hF, 13'h004, "cmp_gt");

    // Result holds between edges even when inputs change mid-cycle.
    run_op(8'd100, 8'd27, 4'h0, 13'd127, "hold_setup");
    a = 8'd1; b = 8'd1; sel = 4'h7;
    #3;
    check("hold_mid_cycle", result, 13'd127);

    // Mid-run reset: result is nonzero, reset clears it without a clock edge.
    run_op(8'd255, 8'd255, 4'h0, 13'h1FE, "pre_reset_nonzero");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_no_edge", result, 13'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held_midrun", result, 13'h0);
    @(negedge clk);
    a = 8'd9; b = 8'd4; sel = 4'h3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_midrun_op", result, 13'd2);

    // Back-to-back random traffic: each result reflects the previous cycle's inputs.
    for (int n = 0; n < 300; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 4'($urandom_range(0, 15));
      // Bias towards b == 0 occasionally so DIV/MOD by zero shows up.
      if ($urandom_range(0, 15) == 0) rb = 8'd0;
      run_op(ra, rb, rs, ref_alu(int'(ra), int'(rb), int'(rs)),
             $sformatf("rand%0d_a%0d_b%0d_sel%0d", n, ra, rb, rs));
    end

    // Result still holds across a mid-cycle input change after random traffic.
    held = result;
    a = ~a; b = ~b; sel = sel + 4'd1;
    #2;
    check("hold_after_random", result, held);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
